// File: rtl/kuznechik_pkg.sv
// Kuznechik (GOST R 34.12-2015) primitives: GF(2^8) multiply, S and L layers,
// and the key-schedule constants, all usable both as logic and at elaboration.
package kuznechik_pkg;

  typedef logic [127:0] block_t;
  typedef logic [255:0] key_t;

  // Low byte of the reduction polynomial x^8+x^7+x^6+x+1.
  localparam logic [7:0] GF_POLY = 8'hC3;

  // Entry 0 weights byte a15 (block[127:120]); entry 15 weights a0.
  localparam logic [7:0] L_COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam logic [7:0] PI [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17, 8'd207, 8'd110, 8'd49, 8'd22, 8'd251, 8'd196, 8'd250, 8'd218, 8'd35, 8'd197, 8'd4, 8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46, 8'd153, 8'd186, 8'd23, 8'd54, 8'd241, 8'd187, 8'd20, 8'd205, 8'd95, 8'd193,
    8'd249, 8'd24, 8'd101, 8'd90, 8'd226, 8'd92, 8'd239, 8'd33, 8'd129, 8'd28, 8'd60, 8'd66, 8'd139, 8'd1, 8'd142, 8'd79,
    8'd5, 8'd132, 8'd2, 8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6, 8'd11, 8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52, 8'd44, 8'd81, 8'd234, 8'd200, 8'd72, 8'd171, 8'd242, 8'd42, 8'd104, 8'd162, 8'd253, 8'd58, 8'd206, 8'd204,
    8'd181, 8'd112, 8'd14, 8'd86, 8'd8, 8'd12, 8'd118, 8'd18, 8'd191, 8'd114, 8'd19, 8'd71, 8'd156, 8'd183, 8'd93, 8'd135,
    8'd21, 8'd161, 8'd150, 8'd41, 8'd16, 8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50, 8'd117, 8'd25, 8'd61, 8'd255, 8'd53, 8'd138, 8'd126, 8'd109, 8'd84, 8'd198, 8'd128, 8'd195, 8'd189, 8'd13, 8'd87,
    8'd223, 8'd245, 8'd36, 8'd169, 8'd62, 8'd168, 8'd67, 8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34, 8'd185, 8'd3,
    8'd224, 8'd15, 8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40, 8'd80, 8'd78, 8'd51, 8'd10, 8'd74,
    8'd167, 8'd151, 8'd96, 8'd115, 8'd30, 8'd0, 8'd98, 8'd68, 8'd26, 8'd184, 8'd56, 8'd130, 8'd100, 8'd159, 8'd38, 8'd65,
    8'd173, 8'd69, 8'd70, 8'd146, 8'd39, 8'd94, 8'd85, 8'd47, 8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7, 8'd88, 8'd179, 8'd64, 8'd134, 8'd172, 8'd29, 8'd247, 8'd48, 8'd55, 8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27, 8'd131, 8'd73, 8'd76, 8'd63, 8'd248, 8'd254, 8'd141, 8'd83, 8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32, 8'd113, 8'd103, 8'd164, 8'd45, 8'd43, 8'd9, 8'd91, 8'd203, 8'd155, 8'd37, 8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89, 8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57, 8'd75, 8'd99, 8'd182
  };

  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Bytes are consumed low-first by shifting, so byte i meets coefficient 15-i.
  function automatic logic [7:0] l_byte(input block_t a);
    logic [7:0] acc;
    block_t     rest;
    acc  = '0;
    rest = a;
    for (int unsigned i = 0; i < 16; i++) begin
      acc  = acc ^ gf_mul8(rest[7:0], L_COEF[4'(15 - i)]);
      rest = rest >> 8;
    end
    return acc;
  endfunction

  function automatic block_t l_transform(input block_t a);
    block_t r;
    r = a;
    for (int unsigned i = 0; i < 16; i++) begin
      r = {l_byte(r), r[127:8]};
    end
    return r;
  endfunction

  function automatic block_t s_transform(input block_t a);
    block_t r;
    block_t rest;
    r    = '0;
    rest = a;
    for (int unsigned i = 0; i < 16; i++) begin
      r    = {PI[rest[7:0]], r[127:8]};
      rest = rest >> 8;
    end
    return r;
  endfunction

  function automatic block_t round_const(input int unsigned idx);
    return l_transform(block_t'(idx));
  endfunction

endpackage

// File: rtl/kuznechik_lsx_round.sv
// One Kuznechik LSX step: result = L(S(data ^ key)), purely combinational.
module kuznechik_lsx_round
  import kuznechik_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] result
);

  block_t mixed;

  assign mixed  = data ^ key;
  assign result = l_transform(s_transform(mixed));

endmodule

// File: rtl/kuznechik_encoder_opt.sv
// Fully combinational Kuznechik encryptor: 32-step Feistel key schedule feeding
// nine LSX rounds and a final whitening XOR. clk/rst_n exist only for interface uniformity.
module kuznechik_encoder_opt
  import kuznechik_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] block,
  input  logic [255:0] key,
  output logic [127:0] encoded
);

  block_t round_key [1:10];
  logic   unused_ok;

  assign unused_ok = &{1'b0, clk, rst_n};

  // Each chain stage lives in its own generate scope so no array feeds itself.
  for (genvar i = 0; i <= 32; i++) begin : g_ks
    block_t hi;
    block_t lo;
    if (i == 0) begin : g_seed
      assign hi = key[255:128];
      assign lo = key[127:0];
    end else begin : g_step
      localparam block_t RC = round_const(i);
      block_t f;
      kuznechik_lsx_round u_lsx (
        .data   (g_ks[i-1].hi),
        .key    (RC),
        .result (f)
      );
      assign hi = f ^ g_ks[i-1].lo;
      assign lo = g_ks[i-1].hi;
    end
  end

  for (genvar j = 0; j < 5; j++) begin : g_rk
    assign round_key[2*j+1] = g_ks[8*j].hi;
    assign round_key[2*j+2] = g_ks[8*j].lo;
  end

  for (genvar r = 0; r <= 9; r++) begin : g_rnd
    block_t st;
    if (r == 0) begin : g_seed
      assign st = block;
    end else begin : g_step
      kuznechik_lsx_round u_lsx (
        .data   (g_rnd[r-1].st),
        .key    (round_key[r]),
        .result (st)
      );
    end
  end

  assign encoded = g_rnd[9].st ^ round_key[10];

endmodule

// File: tb/tb_kuznechik_encoder_opt.sv
// Bench for kuznechik_encoder_opt: RFC 7801 vectors, reset independence, and
// random block/key pairs against a byte-array reference model of the cipher.
module tb_kuznechik_encoder_opt;

  logic         clk;
  logic         rst_n;
  logic [127:0] block;
  logic [255:0] key;
  logic [127:0] encoded;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [127:0] RFC_PT  = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [255:0] RFC_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] RFC_CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;

  kuznechik_encoder_opt dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .block   (block),
    .key     (key),
    .encoded (encoded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient i multiplies byte a_i (a0 = least significant byte).
  localparam logic [7:0] MCOEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  localparam logic [7:0] MPI [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17, 8'd207, 8'd110, 8'd49, 8'd22, 8'd251, 8'd196, 8'd250, 8'd218, 8'd35, 8'd197, 8'd4, 8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46, 8'd153, 8'd186, 8'd23, 8'd54, 8'd241, 8'd187, 8'd20, 8'd205, 8'd95, 8'd193,
    8'd249, 8'd24, 8'd101, 8'd90, 8'd226, 8'd92, 8'd239, 8'd33, 8'd129, 8'd28, 8'd60, 8'd66, 8'd139, 8'd1, 8'd142, 8'd79,
    8'd5, 8'd132, 8'd2, 8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6, 8'd11, 8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52, 8'd44, 8'd81, 8'd234, 8'd200, 8'd72, 8'd171, 8'd242, 8'd42, 8'd104, 8'd162, 8'd253, 8'd58, 8'd206, 8'd204,
    8'd181, 8'd112, 8'd14, 8'd86, 8'd8, 8'd12, 8'd118, 8'd18, 8'd191, 8'd114, 8'd19, 8'd71, 8'd156, 8'd183, 8'd93, 8'd135,
    8'd21, 8'd161, 8'd150, 8'd41, 8'd16, 8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50, 8'd117, 8'd25, 8'd61, 8'd255, 8'd53, 8'd138, 8'd126, 8'd109, 8'd84, 8'd198, 8'd128, 8'd195, 8'd189, 8'd13, 8'd87,
    8'd223, 8'd245, 8'd36, 8'd169, 8'd62, 8'd168, 8'd67, 8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34, 8'd185, 8'd3,
    8'd224, 8'd15, 8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40, 8'd80, 8'd78, 8'd51, 8'd10, 8'd74,
    8'd167, 8'd151, 8'd96, 8'd115, 8'd30, 8'd0, 8'd98, 8'd68, 8'd26, 8'd184, 8'd56, 8'd130, 8'd100, 8'd159, 8'd38, 8'd65,
    8'd173, 8'd69, 8'd70, 8'd146, 8'd39, 8'd94, 8'd85, 8'd47, 8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7, 8'd88, 8'd179, 8'd64, 8'd134, 8'd172, 8'd29, 8'd247, 8'd48, 8'd55, 8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27, 8'd131, 8'd73, 8'd76, 8'd63, 8'd248, 8'd254, 8'd141, 8'd83, 8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32, 8'd113, 8'd103, 8'd164, 8'd45, 8'd43, 8'd9, 8'd91, 8'd203, 8'd155, 8'd37, 8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89, 8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57, 8'd75, 8'd99, 8'd182
  };

  logic [127:0] mcc [1:32];
  logic [127:0] mrk [1:10];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction by 0x1C3.
  function automatic logic [7:0] m_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (((y >> i) & 8'd1) != 8'd0) p = p ^ (16'(x) << i);
    for (int i = 15; i >= 8; i--)
      if (((p >> i) & 16'd1) != 16'd0) p = p ^ (16'h1C3 << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] m_S(input logic [127:0] a);
    logic [7:0]   v [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      v[i] = a[7:0];
      a    = a >> 8;
    end
    r = '0;
    for (int i = 15; i >= 0; i--) r = {r[119:0], MPI[v[i]]};
    return r;
  endfunction

  // Byte register of a0..a15: each step shifts toward a0 and feeds l into a15.
  function automatic logic [127:0] m_L(input logic [127:0] a);
    logic [7:0]   v [16];
    logic [7:0]   t;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      v[i] = a[7:0];
      a    = a >> 8;
    end
    for (int step = 0; step < 16; step++) begin
      t = '0;
      for (int i = 0; i < 16; i++) t = t ^ m_mul(v[i], MCOEF[i]);
      for (int i = 0; i < 15; i++) v[i] = v[i+1];
      v[15] = t;
    end
    r = '0;
    for (int i = 15; i >= 0; i--) r = {r[119:0], v[i]};
    return r;
  endfunction

  function automatic logic [127:0] m_lsx(input logic [127:0] a, input logic [127:0] k);
    return m_L(m_S(a ^ k));
  endfunction

  task automatic model_keys(input logic [255:0] k);
    logic [127:0] a1, a0, t;
    a1 = k[255:128];
    a0 = k[127:0];
    mrk[1] = a1;
    mrk[2] = a0;
    for (int j = 1; j <= 4; j++) begin
      for (int s = 1; s <= 8; s++) begin
        t  = m_lsx(a1, mcc[8*(j-1)+s]) ^ a0;
        a0 = a1;
        a1 = t;
      end
      mrk[2*j+1] = a1;
      mrk[2*j+2] = a0;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [127:0] a;
    a = pt;
    for (int r = 1; r <= 9; r++) a = m_lsx(a, mrk[r]);
    return a ^ mrk[10];
  endfunction

  task automatic apply_and_check(input string tag, input logic [127:0] pt, input logic [255:0] k);
    @(negedge clk);
    block = pt;
    key   = k;
    #1;
    model_keys(k);
    check_eq(tag, encoded, model_enc(pt));
  endtask

  initial begin
    logic [127:0] rb;
    logic [255:0] rk;
    logic [127:0] ones;

    rst_n = 1'b0;
    block = RFC_PT;
    key   = RFC_KEY;
    for (int i = 1; i <= 32; i++) mcc[i] = m_L(128'(i));

    @(posedge clk);
    #1;
    check_eq("rfc_ct_in_reset", encoded, RFC_CT);

    check_eq("pkg_s", kuznechik_pkg::s_transform(128'hffeeddccbbaa99881122334455667700),
             128'hb66cd8887d38e8d77765aeea0c9a7efc);
    check_eq("pkg_l", kuznechik_pkg::l_transform(128'h64a59400000000000000000000000000),
             128'hd456584dd0e3e84cc3166e4b7fa2890d);
    check_eq("pkg_c1", kuznechik_pkg::round_const(1), 128'h6ea276726c487ab85d27bd10dd849401);
    check_eq("k3", dut.round_key[3], 128'hdb31485315694343228d6aef8cc78c44);
    check_eq("k10", dut.round_key[10], 128'h72e9dd7416bcf45b755dbaa88e4a4043);
    check_eq("round1", dut.g_rnd[1].st, 128'he297b686e355b0a1cf4a2f9249140830);

    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check_eq("rfc_ct_reset_held", encoded, RFC_CT);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rfc_ct_reset_released", encoded, RFC_CT);

    // Same-cycle update: change at negedge, observe before the next posedge.
    @(negedge clk);
    block = '0;
    #1;
    model_keys(RFC_KEY);
    check_eq("zero_block_same_cycle", encoded, model_enc('0));
    block = RFC_PT;
    #1;
    check_eq("rfc_ct_restored", encoded, RFC_CT);

    ones = '1;
    apply_and_check("zero_block_zero_key", '0, '0);
    apply_and_check("ones_block_zero_key", ones, '0);
    apply_and_check("zero_block_ones_key", '0, {ones, ones});
    apply_and_check("ones_block_ones_key", ones, {ones, ones});

    for (int n = 0; n < 30; n++) begin
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      if (n % 5 == 0) rk = RFC_KEY;
      rst_n = 1'($urandom_range(0, 1));
      apply_and_check("random", rb, rk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
